m68k_bus_bridge: RTL
====================

# m68k_bus_bridge

Synchronising bridge between the external 68000 CPU bus pins and the internal single-clock request/ack bus that the boot device and SRAM path consume. It samples the asynchronous AS/UDS/LDS/RW/address/data pins and turns each CPU cycle into exactly one internal strobe pulse train, held until `ack`. It then drives DTACK back to the CPU, or BERR on timeout. It also guarantees the strobe release edge (both strobes 1 then 0) that downstream end-of-access detection relies on.

## Interface
- `SYNC_STAGES`, 2, flip-flop stages on `cpu_as_n`, `cpu_uds_n`, `cpu_lds_n` (min 2)
- `TIMEOUT`, 255, cycles in REQ without `ack` before bus error (1..65535)
- `clk` in 1, system clock
- `reset_n` in 1, reset; synchronous, active-low
- `cpu_as_n` in 1, CPU address strobe, async
- `cpu_uds_n` in 1, CPU upper data strobe, async
- `cpu_lds_n` in 1, CPU lower data strobe, async
- `cpu_rw` in 1, CPU read(1)/write(0)
- `cpu_addr` in 23, CPU A[23:1]
- `cpu_data_in` in 16, CPU data pins as seen when CPU drives
- `cpu_data_out` out 16, read data to pins
- `cpu_data_oe` out 1, pin driver enable for `cpu_data_out`
- `cpu_dtack_n` out 1, data transfer acknowledge to CPU
- `cpu_berr_n` out 1, bus error to CPU
- `addr` out 24, internal byte address, bit 0 always 0
- `uds` out 1, internal upper strobe, active-high, selects data[15:8]
- `lds` out 1, internal lower strobe, active-high, selects data[7:0]
- `rw` out 1, internal read(1)/write(0)
- `data_write` out 16, internal write data
- `data_read` in 16, internal read data, valid in the cycle `ack`=1
- `ack` in 1, internal acknowledge, may be combinational from strobes

## Operation
- State machine has five states: RELEASE, IDLE, REQ, ACKED, ERROR.
- **RELEASE:** all strobes 0, dtack_n=1, berr_n=1, oe=0. Exits to IDLE when the synchronised AS is 1.
- **IDLE:** waits for synced AS=0 and synced (UDS=0 or LDS=0).
  - Same edge captures `cpu_addr`→`addr[23:1]`, `cpu_rw`→`rw` and `cpu_data_in`→`data_write` from the raw pins. These are stable by the time the synced DS arrives.
  - Same edge captures inverted synced strobes →`uds`/`lds`, then goes to REQ.
- **REQ:** `uds`/`lds` held at captured values; timeout counter increments each cycle.
  - If `ack`=1: latch `data_read` into `cpu_data_out` when rw=1, clear `uds`/`lds`, set dtack_n=0, go to ACKED.
  - Else if counter = TIMEOUT-1: clear `uds`/`lds`, set berr_n=0, go to ERROR.
- **ACKED:** dtack_n=0; oe = captured rw. On synced AS=1: dtack_n=1, oe=0, go to IDLE.
- **ERROR:** berr_n=0; on synced AS=1: berr_n=1, go to IDLE.
- `addr`, `rw` and `data_write` hold their values from capture until the next capture.
- Strobes are 0 in every state except REQ, so every access ends with at least one cycle of uds=lds=0.
- Counter clears on entry to REQ. Width is ceil(log2(TIMEOUT+1)).
- Internal address is `{cpu_addr, 1'b0}`; no byte-address arithmetic.

## Timing
- Reset values:
  - state=RELEASE
  - uds=lds=0, rw=1, addr=0, data_write=0
  - cpu_data_out=0, cpu_data_oe=0, cpu_dtack_n=1, cpu_berr_n=1
  - counter=0
- Reset mid-cycle aborts the access with no DTACK or BERR. The bridge stays in RELEASE until the CPU drops AS.
- Pin-to-strobe latency: SYNC_STAGES+1 clocks from DS falling to `uds`/`lds` asserted.
- `ack` in the first REQ cycle gives dtack_n=0 one clock later; strobes are asserted for exactly one cycle.
- DTACK release: SYNC_STAGES+1 clocks after AS rises.
- `ack` and timeout in the same cycle: `ack` wins.
- `ack` outside REQ is ignored.
- AS rising while in REQ (CPU abort) is ignored; the internal access completes, then the bridge returns through ACKED or ERROR.
- Back-to-back CPU cycles: a new capture can only occur from IDLE, i.e. after AS was seen high.

## Test plan
- Word read at 0x000100, `ack` combinational from strobes, data_read=0x4E71 → uds=lds=1 for 1 cycle, addr=0x000100, dtack_n=0, cpu_data_out=0x4E71, oe=1 until AS high.
- Byte write to 0x000001 (lds_n=0 only), data 0x00A9 → uds=0, lds=1, rw=0, data_write=0x00A9, oe stays 0.
- Word write of 0xA9A9 at 0x000000 then AS release → strobes go 11→00 exactly once, and both stay 0 through the idle gap.
- No `ack` with TIMEOUT=8 → strobes drop after 8 REQ cycles, berr_n=0, dtack_n stays 1, berr_n=1 after AS high.
- reset_n=0 in REQ with AS held low → all outputs at reset values; no new request until AS goes high then low again.
- Two reads back-to-back with AS high for 1 CPU clock → two separate strobe pulses, with uds=lds=0 for at least 1 cycle between them.

Source files
------------

// File: rtl/m68k_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : m68k_bus_bridge
// Purpose  : Synchronises the asynchronous 68000 bus pins and converts each
//            CPU cycle into one internal uds/lds strobe pulse held until ack,
//            answering the CPU with DTACK, or with BERR on timeout.
// Revision : 1.0 - initial release
// ============================================================================
module m68k_bus_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_as_n,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic        cpu_rw,
  input  logic [22:0] cpu_addr,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  output logic        cpu_data_oe,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  output logic [23:0] addr,
  output logic        uds,
  output logic        lds,
  output logic        rw,
  output logic [15:0] data_write,
  input  logic [15:0] data_read,
  input  logic        ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_RELEASE = 3'd0,
    ST_IDLE    = 3'd1,
    ST_REQ     = 3'd2,
    ST_ACKED   = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] as_sync_q, as_sync_d;
  logic [SYNC_STAGES-1:0] uds_sync_q, uds_sync_d;
  logic [SYNC_STAGES-1:0] lds_sync_q, lds_sync_d;
  logic                   as_s, uds_s, lds_s;
  logic [22:0]            addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic [15:0]            data_write_q, data_write_d;
  logic                   uds_q, uds_d, lds_q, lds_d;
  logic [15:0]            data_out_q, data_out_d;
  logic                   oe_q, oe_d;
  logic                   dtack_n_q, dtack_n_d;
  logic                   berr_n_q, berr_n_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Synchroniser shift for the three strobe pins. Reset clears the chains to
  // "asserted" so a CPU still holding AS low after reset is never mistaken
  // for a released bus.
  always_comb begin
    as_sync_d  = {as_sync_q[SYNC_STAGES-2:0], cpu_as_n};
    uds_sync_d = {uds_sync_q[SYNC_STAGES-2:0], cpu_uds_n};
    lds_sync_d = {lds_sync_q[SYNC_STAGES-2:0], cpu_lds_n};
  end

  assign as_s  = as_sync_q[SYNC_STAGES-1];
  assign uds_s = uds_sync_q[SYNC_STAGES-1];
  assign lds_s = lds_sync_q[SYNC_STAGES-1];

  // Next-state and output logic of the access sequencer.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    data_write_d = data_write_q;
    uds_d        = uds_q;
    lds_d        = lds_q;
    data_out_d   = data_out_q;
    oe_d         = oe_q;
    dtack_n_d    = dtack_n_q;
    berr_n_d     = berr_n_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_RELEASE: begin
        if (as_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // Address/data/rw pins settled long before the synced DS edge arrives.
        if (!as_s && (!uds_s || !lds_s)) begin
          addr_d       = cpu_addr;
          rw_d         = cpu_rw;
          data_write_d = cpu_data_in;
          uds_d        = !uds_s;
          lds_d        = !lds_s;
          cnt_d        = '0;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        // ack is checked first so it wins over a simultaneous timeout.
        if (ack) begin
          if (rw_q) data_out_d = data_read;
          uds_d     = 1'b0;
          lds_d     = 1'b0;
          dtack_n_d = 1'b0;
          oe_d      = rw_q;
          state_d   = ST_ACKED;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          uds_d    = 1'b0;
          lds_d    = 1'b0;
          berr_n_d = 1'b0;
          state_d  = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACKED: begin
        if (as_s) begin
          dtack_n_d = 1'b1;
          oe_d      = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (as_s) begin
          berr_n_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_RELEASE;
    endcase
  end

  // State, synchroniser and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_RELEASE;
      as_sync_q    <= '0;
      uds_sync_q   <= '0;
      lds_sync_q   <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b1;
      data_write_q <= '0;
      uds_q        <= 1'b0;
      lds_q        <= 1'b0;
      data_out_q   <= '0;
      oe_q         <= 1'b0;
      dtack_n_q    <= 1'b1;
      berr_n_q     <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      as_sync_q    <= as_sync_d;
      uds_sync_q   <= uds_sync_d;
      lds_sync_q   <= lds_sync_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      data_write_q <= data_write_d;
      uds_q        <= uds_d;
      lds_q        <= lds_d;
      data_out_q   <= data_out_d;
      oe_q         <= oe_d;
      dtack_n_q    <= dtack_n_d;
      berr_n_q     <= berr_n_d;
      cnt_q        <= cnt_d;
    end
  end

  assign addr         = {addr_q, 1'b0};
  assign rw           = rw_q;
  assign data_write   = data_write_q;
  assign uds          = uds_q;
  assign lds          = lds_q;
  assign cpu_data_out = data_out_q;
  assign cpu_data_oe  = oe_q;
  assign cpu_dtack_n  = dtack_n_q;
  assign cpu_berr_n   = berr_n_q;

endmodule
`default_nettype wire
